// File: rtl/demorgan_check_seq.sv
// Sequencer and self-check controller for the De Morgan gate blocks.
// Drives the four (A,B) vectors, waits a settle time after each, and grades the gate outputs.
module demorgan_check_seq #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       drv_a,
    output logic       drv_b,
    input  logic       obs_nanb,
    input  logic       obs_nor,
    input  logic       obs_nanob,
    input  logic       obs_nand,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_vec,
    output logic [1:0] fail_law
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } stateType;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    stateType         state, stateNext;
    logic [1:0]       vec, vecNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [2:0]       errCount, errNext;
    logic [1:0]       failVec, failVecNext;
    logic [1:0]       failLaw, failLawNext;
    logic             passReg, passNext;

    logic expAnd, expOr, mismatchAnd, mismatchOr;

    // Golden values for the current vector; the gate outputs only matter on the CHECK cycle.
    assign expAnd      = ~vec[1] & ~vec[0];
    assign expOr       = ~(vec[1] & vec[0]);
    assign mismatchAnd = (obs_nanb != expAnd) | (obs_nor != expAnd);
    assign mismatchOr  = (obs_nanob != expOr) | (obs_nand != expOr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec      <= 2'b00;
            cnt      <= '0;
            errCount <= 3'd0;
            failVec  <= 2'b00;
            failLaw  <= 2'b00;
            passReg  <= 1'b0;
        end else begin
            state    <= stateNext;
            vec      <= vecNext;
            cnt      <= cntNext;
            errCount <= errNext;
            failVec  <= failVecNext;
            failLaw  <= failLawNext;
            passReg  <= passNext;
        end
    end

    always_comb begin
        stateNext   = state;
        vecNext     = vec;
        cntNext     = cnt;
        errNext     = errCount;
        failVecNext = failVec;
        failLawNext = failLaw;
        passNext    = passReg;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    stateNext   = SETTLE;
                    vecNext     = 2'b00;
                    cntNext     = RELOAD;
                    errNext     = 3'd0;
                    failVecNext = 2'b00;
                    failLawNext = 2'b00;
                    passNext    = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    stateNext = IDLE;
                    vecNext   = 2'b00;
                    passNext  = 1'b0;
                end else if (cnt == '0) begin
                    stateNext = CHECK;
                end else begin
                    cntNext = cnt - ONE;
                end
            end
            CHECK: begin
                if (abort) begin
                    stateNext = IDLE;
                    vecNext   = 2'b00;
                    passNext  = 1'b0;
                end else begin
                    if (mismatchAnd || mismatchOr) begin
                        errNext     = errCount + 3'd1;
                        failLawNext = failLaw | {mismatchOr, mismatchAnd};
                        if (errCount == 3'd0) begin
                            failVecNext = vec;
                        end
                    end
                    // pass is settled on entry to DONE so it is valid alongside the done pulse.
                    if (vec == 2'b11) begin
                        stateNext = DONE;
                        passNext  = (errNext == 3'd0);
                    end else begin
                        stateNext = SETTLE;
                        vecNext   = vec + 2'd1;
                        cntNext   = RELOAD;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
                vecNext   = 2'b00;
            end
            default: begin
                stateNext = IDLE;
                vecNext   = 2'b00;
            end
        endcase
    end

    assign drv_a     = vec[1];
    assign drv_b     = vec[0];
    assign busy      = (state == SETTLE) || (state == CHECK);
    assign done      = (state == DONE);
    assign pass      = passReg;
    assign err_count = errCount;
    assign fail_vec  = failVec;
    assign fail_law  = failLaw;

endmodule

// File: tb/tb_demorgan_check_seq.sv
// Self-checking bench for demorgan_check_seq: fault-injected gate models, randomized fault
// patterns, and a vector-by-vector reference model of the expected run results.
module tb_demorgan_check_seq;

    logic       clk;
    logic       rst_n;
    logic       start, abort;
    logic       drv_a, drv_b;
    logic       obs_nanb, obs_nor, obs_nanob, obs_nand;
    logic       busy, done, pass;
    logic [2:0] err_count;
    logic [1:0] fail_vec, fail_law;

    logic       start4, abort4;
    logic       drv_a4, drv_b4;
    logic       obs_nanb4, obs_nor4, obs_nanob4, obs_nand4;
    logic       busy4, done4, pass4;
    logic [2:0] err_count4;
    logic [1:0] fail_vec4, fail_law4;

    // Fault modes per gate output: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
    logic [1:0] modeNanb, modeNor, modeNanob, modeNand;

    int vectorCount = 0;
    int missCount   = 0;

    function automatic logic faultyValue(input logic g, input logic [1:0] mode);
        case (mode)
            2'd0:    faultyValue = g;
            2'd1:    faultyValue = 1'b0;
            2'd2:    faultyValue = 1'b1;
            default: faultyValue = ~g;
        endcase
    endfunction

    assign obs_nanb   = faultyValue(~drv_a & ~drv_b, modeNanb);
    assign obs_nor    = faultyValue(~(drv_a | drv_b), modeNor);
    assign obs_nanob  = faultyValue(~drv_a | ~drv_b, modeNanob);
    assign obs_nand   = faultyValue(~(drv_a & drv_b), modeNand);
    assign obs_nanb4  = faultyValue(~drv_a4 & ~drv_b4, modeNanb);
    assign obs_nor4   = faultyValue(~(drv_a4 | drv_b4), modeNor);
    assign obs_nanob4 = faultyValue(~drv_a4 | ~drv_b4, modeNanob);
    assign obs_nand4  = faultyValue(~(drv_a4 & drv_b4), modeNand);

    demorgan_check_seq #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .drv_a(drv_a), .drv_b(drv_b),
        .obs_nanb(obs_nanb), .obs_nor(obs_nor), .obs_nanob(obs_nanob), .obs_nand(obs_nand),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec), .fail_law(fail_law)
    );

    demorgan_check_seq #(.SETTLE_CYCLES(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .drv_a(drv_a4), .drv_b(drv_b4),
        .obs_nanb(obs_nanb4), .obs_nor(obs_nor4), .obs_nanob(obs_nanob4), .obs_nand(obs_nand4),
        .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err_count4), .fail_vec(fail_vec4), .fail_law(fail_law4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: grade each of the four vectors directly from the gate truth tables.
    task automatic modelRun(output int expErr, output logic [1:0] expVec, output logic [1:0] expLaw);
        logic a, b, e1, e2, m1, m2;
        expErr = 0;
        expVec = 2'b00;
        expLaw = 2'b00;
        for (int v = 0; v < 4; v++) begin
            a  = (v >= 2);
            b  = (v % 2 == 1);
            e1 = !a && !b;
            e2 = !(a && b);
            m1 = (faultyValue(e1, modeNanb) != e1) || (faultyValue(e1, modeNor) != e1);
            m2 = (faultyValue(e2, modeNanob) != e2) || (faultyValue(e2, modeNand) != e2);
            if (m1 || m2) begin
                if (expErr == 0) expVec = 2'(v);
                expErr++;
                expLaw = expLaw | {m2, m1};
            end
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mA, input logic [1:0] mB,
                                 input logic [1:0] mC, input logic [1:0] mD);
        modeNanb  = mA;
        modeNor   = mB;
        modeNanob = mC;
        modeNand  = mD;
    endtask

    // One full run on the SETTLE_CYCLES=2 instance, optionally re-pulsing start while busy
    // and/or pulsing start during the done cycle.
    task automatic runAndCheck(input bit repulse, input bit startInDone);
        int         doneCycle;
        int         extraDone;
        int         expErr;
        logic [1:0] expVec, expLaw;
        modelRun(expErr, expVec, expLaw);
        doneCycle = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k <= 12) begin
                checkOutput("drv", {drv_a, drv_b}, 32'((k - 1) / 3));
                checkOutput("busy", busy, 1);
            end
            if (done) begin
                doneCycle = k;
                break;
            end
            start = repulse && (k == 4 || k == 8);
            @(negedge clk);
        end
        checkOutput("doneCycle", doneCycle, 13);
        checkOutput("pass", pass, (expErr == 0));
        checkOutput("errCount", err_count, expErr);
        if (expErr != 0) checkOutput("failVec", fail_vec, expVec);
        checkOutput("failLaw", fail_law, expLaw);
        start = startInDone;
        @(negedge clk) start = 1'b0;
        checkOutput("doneAfter", done, 0);
        checkOutput("busyAfter", busy, 0);
        checkOutput("drvAfter", {drv_a, drv_b}, 0);
        checkOutput("passHeld", pass, (expErr == 0));
        extraDone = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (done || busy) extraDone++;
        end
        checkOutput("noExtraRun", extraDone, 0);
    endtask

    initial begin
        int         doneCycle;
        int         expErr;
        int         doneSeen;
        logic [1:0] expVec, expLaw;

        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start4 = 1'b0;
        abort4 = 1'b0;
        applyStimulus(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("rstDrv", {drv_a, drv_b}, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstPass", pass, 0);
        checkOutput("rstErr", err_count, 0);
        checkOutput("rstFailVec", fail_vec, 0);
        checkOutput("rstFailLaw", fail_law, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed fault patterns");
        applyStimulus(0, 0, 0, 0);
        runAndCheck(1'b0, 1'b0);
        applyStimulus(0, 1, 0, 0);
        runAndCheck(1'b0, 1'b0);
        applyStimulus(0, 0, 0, 2);
        runAndCheck(1'b0, 1'b0);
        applyStimulus(3, 0, 3, 0);
        runAndCheck(1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0);
        runAndCheck(1'b1, 1'b1);

        $display("[TB] randomized fault patterns");
        for (int r = 0; r < 16; r++) begin
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            runAndCheck(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] start and abort together in idle");
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        checkOutput("startAbortBusy", busy, 0);
        @(negedge clk);
        checkOutput("startAbortBusy2", busy, 0);

        $display("[TB] abort mid-run");
        applyStimulus(0, 1, 0, 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k < 5; k++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortDrv", {drv_a, drv_b}, 0);
        checkOutput("abortPass", pass, 0);
        checkOutput("abortErr", err_count, 1);
        checkOutput("abortFailVec", fail_vec, 0);
        checkOutput("abortFailLaw", fail_law, 1);
        doneSeen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("abortNoDone", doneSeen, 0);

        $display("[TB] async reset mid-run");
        applyStimulus(3, 0, 3, 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k < 7; k++) @(negedge clk);
        checkOutput("preResetErr", err_count, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstDrv", {drv_a, drv_b}, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        checkOutput("midRstPass", pass, 0);
        checkOutput("midRstErr", err_count, 0);
        checkOutput("midRstFailVec", fail_vec, 0);
        checkOutput("midRstFailLaw", fail_law, 0);
        @(negedge clk) rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0);
        runAndCheck(1'b0, 1'b0);

        $display("[TB] SETTLE_CYCLES=4 instance");
        for (int r = 0; r < 3; r++) begin
            if (r == 0) applyStimulus(0, 0, 0, 0);
            else applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            modelRun(expErr, expVec, expLaw);
            doneCycle = -1;
            @(negedge clk) start4 = 1'b1;
            @(negedge clk) start4 = 1'b0;
            for (int k = 1; k <= 60; k++) begin
                if (k <= 20) checkOutput("drv4", {drv_a4, drv_b4}, 32'((k - 1) / 5));
                if (done4) begin
                    doneCycle = k;
                    break;
                end
                @(negedge clk);
            end
            checkOutput("doneCycle4", doneCycle, 21);
            checkOutput("pass4", pass4, (expErr == 0));
            checkOutput("errCount4", err_count4, expErr);
            if (expErr != 0) checkOutput("failVec4", fail_vec4, expVec);
            checkOutput("failLaw4", fail_law4, expLaw);
            repeat (3) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/demorgan_check_seq.md
Name: demorgan_check_seq

Overview:
- Sequencer/self-check controller for the four De Morgan gate blocks: the two AND-form inverters, the NAND form, the three-gate OR form and the NOR form.
- On `start` it drives all four (A,B) vectors onto a shared input pair and waits a programmable settle time after each.
- For each vector it checks the AND-form inverter, NOR, OR-form and NAND outputs against golden values, then reports pass/fail, an error count and the first failing vector.
- Sits beside the gate blocks as their test/bring-up controller.

Parameters:
SETTLE_CYCLES, 2, cycles to wait after driving a vector before sampling outputs; legal range 1..15
CNT_W, 4, width of the internal settle counter; must hold SETTLE_CYCLES

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a 4-vector run; sampled only in IDLE
abort  input  1  cancel a run in progress; return to IDLE
drv_a  output  1  A input driven to all gate blocks
drv_b  output  1  B input driven to all gate blocks
obs_nanb  input  1  (~A)*(~B) output of the AND-form inverter block
obs_nor  input  1  ~(A+B) output of the NOR block
obs_nanob  input  1  (~A)+(~B) output of the OR-form block
obs_nand  input  1  ~(A*B) output of the NAND block
busy  output  1  high from the cycle after start through the last CHECK
done  output  1  one-cycle pulse at run completion
pass  output  1  1 if the last completed run had zero errors; held until next start
err_count  output  3  number of failing vectors in the current/last run (0..4)
fail_vec  output  2  {A,B} of the first failing vector; valid when err_count!=0
fail_law  output  2  sticky OR across the run; bit0 = AND/NOR pair mismatch, bit1 = OR/NAND pair mismatch

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; drv_a=drv_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_law=0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1:
  - Load vec=00 and drive drv_a/drv_b = vec.
  - Clear err_count, fail_vec, fail_law and pass.
  - Settle counter = SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: busy=1. Decrement the counter each cycle; at 0 go to CHECK. This holds SETTLE_CYCLES cycles.
- CHECK (one cycle), for vec=(a,b):
  - e1 = ~a&~b, e2 = ~(a&b).
  - m1 = (obs_nanb!=e1)|(obs_nor!=e1).
  - m2 = (obs_nanob!=e2)|(obs_nand!=e2).
  - If m1|m2: err_count+1. If err_count was 0, capture fail_vec=vec. fail_law |= {m2,m1}.
  - If vec==11, go to DONE. Otherwise vec+1, drive the new vec, reload the counter, go to SETTLE.
- Vector order: 00, 01, 10, 11, with {drv_a,drv_b}=vec.
- DONE (one cycle): busy=0, done=1, pass=(err_count==0). Go to IDLE; drv_a/drv_b return to 0.
- Latency: done is high in cycle 4*(SETTLE_CYCLES+1)+1 after the start-sampling edge. With the default, that is cycle 13.
- start while not IDLE: ignored. start coincident with abort in IDLE: abort wins, no run.
- abort in SETTLE or CHECK: go to IDLE next edge; busy=0, drv=00, pass=0; done not pulsed. err_count, fail_vec and fail_law hold their partial values.
- start in the DONE cycle: ignored; a new start is accepted from IDLE in the following cycle.
- Observed inputs are treated as synchronous: sampled only on the CHECK edge, never in SETTLE.
- err_count saturates naturally at 4; no wrap is possible.
- Async reset mid-run aborts immediately to reset values.

Test Plan:
- Correct gates, SETTLE_CYCLES=2, start pulse -> drv sequence 00,01,10,11 each held 3 cycles. done at cycle 13, pass=1, err_count=0, fail_law=00.
- obs_nor stuck 0 -> mismatch only at vector 00. err_count=1, fail_vec=00, fail_law=01, pass=0.
- obs_nand stuck 1 -> mismatch only at vector 11. err_count=1, fail_vec=11, fail_law=10.
- obs_nanb and obs_nanob both inverted -> all 4 vectors fail. err_count=4, fail_vec=00, fail_law=11.
- start re-pulsed while busy -> ignored, single done at cycle 13. abort at cycle 5 -> IDLE at cycle 6, no done, pass=0, drv=00.
- rst_n low at cycle 7, then start again -> all outputs at reset values. SETTLE_CYCLES=4 variant gives done at cycle 21.
